// File: rtl/trig_pkg.sv
// Shared constants, FSM encoding and helpers for the quarter-wave sine/cosine lookup server.
// The fixed-point format is Q2.13: 1.0 = 8192 in a 16-bit signed word.
package trig_pkg;

   localparam int TRIG_FRAC_BITS = 13;
   localparam int TRIG_ROM_DEPTH = 91;

   localparam logic [8:0] ANG_90  = 9'd90;
   localparam logic [8:0] ANG_180 = 9'd180;
   localparam logic [8:0] ANG_270 = 9'd270;
   localparam logic [8:0] ANG_360 = 9'd360;

   typedef enum logic [2:0] {
      IDLE,
      REDUCE,
      RD_SIN,
      WAIT_SIN,
      RD_COS,
      WAIT_COS,
      DONE
   } state_t;

   // Two's-complement negation; -0 stays 0 and 8192 maps to -8192 without overflow.
   function automatic logic [15:0] neg16(input logic [15:0] v);
      return ~v + 16'd1;
   endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table T[i] = round(2^FRAC_BITS * sin(i deg)), i = 0..90, with a registered read.
// Addresses past the last entry are clamped to it.
module quarter_sine_rom
   import trig_pkg::*;
#(
   parameter int FRAC_BITS = TRIG_FRAC_BITS,
   parameter int ROM_DEPTH = TRIG_ROM_DEPTH
) (
   input  logic        clk,
   input  logic [8:0]  addr_i,
   output logic [15:0] data_o
);

   logic [8:0]  addr_c;
   logic [15:0] entry;
   logic [15:0] data_q;

   assign addr_c = (addr_i > 9'(ROM_DEPTH - 1)) ? 9'(ROM_DEPTH - 1) : addr_i;

   always_comb begin
      entry = 16'(1 << FRAC_BITS);
      case (addr_c)
         9'd0:  entry = 16'd0;    9'd1:  entry = 16'd143;  9'd2:  entry = 16'd286;  9'd3:  entry = 16'd429;
         9'd4:  entry = 16'd571;  9'd5:  entry = 16'd714;  9'd6:  entry = 16'd856;  9'd7:  entry = 16'd998;
         9'd8:  entry = 16'd1140; 9'd9:  entry = 16'd1282; 9'd10: entry = 16'd1423; 9'd11: entry = 16'd1563;
         9'd12: entry = 16'd1703; 9'd13: entry = 16'd1843; 9'd14: entry = 16'd1982; 9'd15: entry = 16'd2120;
         9'd16: entry = 16'd2258; 9'd17: entry = 16'd2395; 9'd18: entry = 16'd2531; 9'd19: entry = 16'd2667;
         9'd20: entry = 16'd2802; 9'd21: entry = 16'd2936; 9'd22: entry = 16'd3069; 9'd23: entry = 16'd3201;
         9'd24: entry = 16'd3332; 9'd25: entry = 16'd3462; 9'd26: entry = 16'd3591; 9'd27: entry = 16'd3719;
         9'd28: entry = 16'd3846; 9'd29: entry = 16'd3972; 9'd30: entry = 16'd4096; 9'd31: entry = 16'd4219;
         9'd32: entry = 16'd4341; 9'd33: entry = 16'd4462; 9'd34: entry = 16'd4581; 9'd35: entry = 16'd4699;
         9'd36: entry = 16'd4815; 9'd37: entry = 16'd4930; 9'd38: entry = 16'd5043; 9'd39: entry = 16'd5155;
         9'd40: entry = 16'd5266; 9'd41: entry = 16'd5374; 9'd42: entry = 16'd5482; 9'd43: entry = 16'd5587;
         9'd44: entry = 16'd5691; 9'd45: entry = 16'd5793; 9'd46: entry = 16'd5893; 9'd47: entry = 16'd5991;
         9'd48: entry = 16'd6088; 9'd49: entry = 16'd6183; 9'd50: entry = 16'd6275; 9'd51: entry = 16'd6366;
         9'd52: entry = 16'd6455; 9'd53: entry = 16'd6542; 9'd54: entry = 16'd6627; 9'd55: entry = 16'd6710;
         9'd56: entry = 16'd6791; 9'd57: entry = 16'd6870; 9'd58: entry = 16'd6947; 9'd59: entry = 16'd7022;
         9'd60: entry = 16'd7094; 9'd61: entry = 16'd7165; 9'd62: entry = 16'd7233; 9'd63: entry = 16'd7299;
         9'd64: entry = 16'd7363; 9'd65: entry = 16'd7424; 9'd66: entry = 16'd7484; 9'd67: entry = 16'd7541;
         9'd68: entry = 16'd7595; 9'd69: entry = 16'd7648; 9'd70: entry = 16'd7698; 9'd71: entry = 16'd7746;
         9'd72: entry = 16'd7791; 9'd73: entry = 16'd7834; 9'd74: entry = 16'd7874; 9'd75: entry = 16'd7913;
         9'd76: entry = 16'd7949; 9'd77: entry = 16'd7982; 9'd78: entry = 16'd8013; 9'd79: entry = 16'd8041;
         9'd80: entry = 16'd8068; 9'd81: entry = 16'd8091; 9'd82: entry = 16'd8112; 9'd83: entry = 16'd8131;
         9'd84: entry = 16'd8147; 9'd85: entry = 16'd8161; 9'd86: entry = 16'd8172; 9'd87: entry = 16'd8181;
         9'd88: entry = 16'd8187; 9'd89: entry = 16'd8191;
         default: entry = 16'(1 << FRAC_BITS);
      endcase
   end

   always_ff @(posedge clk) begin
      data_q <= entry;
   end

   assign data_o = data_q;

endmodule

// File: rtl/trig_lut_server.sv
// Angle-to-(cos, sin) lookup server: folds a whole-degree angle into a quadrant and offset,
// reads the quarter-wave table twice and presents signed results with a fixed 6-cycle latency.
module trig_lut_server
   import trig_pkg::*;
#(
   parameter int FRAC_BITS = TRIG_FRAC_BITS,
   parameter int ROM_DEPTH = TRIG_ROM_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [8:0]  theta,
   output logic [15:0] cos_q,
   output logic [15:0] sin_q,
   output logic        busy,
   output logic        valid
);

   state_t      state_q, state_d;
   logic        accept;
   logic [8:0]  theta_q;
   logic [8:0]  theta_fold;
   logic [1:0]  quad_q, quad_d;
   logic [8:0]  off_q, off_d;
   logic [15:0] sin_raw_q;
   logic        mirror;
   logic        neg_sin, neg_cos;
   logic [8:0]  sin_idx, cos_idx;
   logic [8:0]  rom_addr;
   logic [15:0] rom_data;

   assign accept = en && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      valid   = 1'b0;
      case (state_q)
         IDLE:     if (en) state_d = REDUCE;
         REDUCE:   begin state_d = RD_SIN;   busy = 1'b1; end
         RD_SIN:   begin state_d = WAIT_SIN; busy = 1'b1; end
         WAIT_SIN: begin state_d = RD_COS;   busy = 1'b1; end
         RD_COS:   begin state_d = WAIT_COS; busy = 1'b1; end
         WAIT_COS: begin state_d = DONE;     busy = 1'b1; end
         DONE: begin
            valid   = 1'b1;
            state_d = en ? REDUCE : IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   // Boundary angles 90/180/270 stay in the lower quadrant with offset 90.
   always_comb begin
      theta_fold = theta_q;
      if (theta_q >= ANG_360) theta_fold = theta_q - ANG_360;
      quad_d = 2'd0;
      off_d  = theta_fold;
      if (theta_fold > ANG_270) begin
         quad_d = 2'd3;
         off_d  = theta_fold - ANG_270;
      end else if (theta_fold > ANG_180) begin
         quad_d = 2'd2;
         off_d  = theta_fold - ANG_180;
      end else if (theta_fold > ANG_90) begin
         quad_d = 2'd1;
         off_d  = theta_fold - ANG_90;
      end
   end

   assign mirror   = quad_q[0];
   assign neg_sin  = quad_q[1];
   assign neg_cos  = quad_q[0] ^ quad_q[1];
   assign sin_idx  = mirror ? (ANG_90 - off_q) : off_q;
   assign cos_idx  = mirror ? off_q : (ANG_90 - off_q);
   assign rom_addr = (state_q == RD_COS) ? cos_idx : sin_idx;

   quarter_sine_rom #(
      .FRAC_BITS (FRAC_BITS),
      .ROM_DEPTH (ROM_DEPTH)
   ) u_rom (
      .clk    (clk),
      .addr_i (rom_addr),
      .data_o (rom_data)
   );

   // Results land in both outputs on the same edge so they never change while busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         theta_q   <= '0;
         quad_q    <= '0;
         off_q     <= '0;
         sin_raw_q <= '0;
         cos_q     <= '0;
         sin_q     <= '0;
      end else begin
         if (accept) theta_q <= theta;
         if (state_q == REDUCE) begin
            quad_q <= quad_d;
            off_q  <= off_d;
         end
         if (state_q == WAIT_SIN) sin_raw_q <= rom_data;
         if (state_q == WAIT_COS) begin
            cos_q <= neg_cos ? neg16(rom_data) : rom_data;
            sin_q <= neg_sin ? neg16(sin_raw_q) : sin_raw_q;
         end
      end
   end

endmodule

// File: tb/tb_trig_lut_server.sv
// Directed bench for trig_lut_server: table of single requests plus back-to-back,
// ignored-strobe and mid-request reset sequences.
module tb_trig_lut_server;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [8:0]  theta;
   logic [15:0] cos_q;
   logic [15:0] sin_q;
   logic        busy;
   logic        valid;

   int checks = 0;
   int errors = 0;
   int hold_cos = 0;
   int hold_sin = 0;

   typedef struct {
      int th;
      int c;
      int s;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   trig_lut_server dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .theta (theta),
      .cos_q (cos_q),
      .sin_q (sin_q),
      .busy  (busy),
      .valid (valid)
   );

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Single en pulse; checks busy window, held outputs, DONE cycle and return to IDLE.
   task automatic run_request(input int th, input int ec, input int es);
      @(negedge clk);
      en    = 1'b1;
      theta = 9'(th);
      @(negedge clk);
      en    = 1'b0;
      theta = 9'd123;
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) @(negedge clk);
         check($sformatf("busy th=%0d c=%0d", th, c), int'(busy), 1);
         check($sformatf("valid th=%0d c=%0d", th, c), int'(valid), 0);
         check($sformatf("cos_hold th=%0d c=%0d", th, c), s16(cos_q), hold_cos);
         check($sformatf("sin_hold th=%0d c=%0d", th, c), s16(sin_q), hold_sin);
      end
      @(negedge clk);
      check($sformatf("valid_done th=%0d", th), int'(valid), 1);
      check($sformatf("busy_done th=%0d", th), int'(busy), 0);
      check($sformatf("cos th=%0d", th), s16(cos_q), ec);
      check($sformatf("sin th=%0d", th), s16(sin_q), es);
      hold_cos = ec;
      hold_sin = es;
      $display("req theta=%0d -> cos=%0d sin=%0d (expected %0d %0d)", th, s16(cos_q), s16(sin_q), ec, es);
      @(negedge clk);
      check($sformatf("valid_idle th=%0d", th), int'(valid), 0);
   endtask

   initial begin
      int vcount;

      vecs[0] = '{45, 5793, 5793};
      vecs[1] = '{90, 0, 8192};
      vecs[2] = '{180, -8192, 0};
      vecs[3] = '{270, 0, -8192};
      vecs[4] = '{0, 8192, 0};
      vecs[5] = '{120, -4096, 7094};
      vecs[6] = '{330, 7094, -4096};
      vecs[7] = '{400, 6275, 5266};
      vecs[8] = '{40, 6275, 5266};
      vecs[9] = '{359, 8191, -143};

      // Reset held with en asserted: reset must win.
      rst   = 1'b0;
      en    = 1'b1;
      theta = 9'd45;
      repeat (3) @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset valid", int'(valid), 0);
      check("reset cos", s16(cos_q), 0);
      check("reset sin", s16(sin_q), 0);
      $display("reset -> busy=%0d valid=%0d cos=%0d sin=%0d", busy, valid, s16(cos_q), s16(sin_q));
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_request(vecs[i].th, vecs[i].c, vecs[i].s);
      end

      // en held high: one result every 6 cycles.
      @(negedge clk);
      en    = 1'b1;
      theta = 9'd30;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         check($sformatf("b2b valid c=%0d", c), int'(valid), (c % 6 == 0) ? 1 : 0);
         check($sformatf("b2b busy c=%0d", c), int'(busy), (c % 6 == 0) ? 0 : 1);
         if (c % 6 == 0) begin
            check($sformatf("b2b cos c=%0d", c), s16(cos_q), 7094);
            check($sformatf("b2b sin c=%0d", c), s16(sin_q), 4096);
            $display("b2b result c=%0d -> cos=%0d sin=%0d", c, s16(cos_q), s16(sin_q));
         end
         if (c == 18) en = 1'b0;
      end
      hold_cos = 7094;
      hold_sin = 4096;
      @(negedge clk);
      check("b2b idle valid", int'(valid), 0);
      check("b2b idle busy", int'(busy), 0);

      run_request(0, 8192, 0);

      // en pulse with theta=60 while busy must be dropped.
      @(negedge clk);
      en    = 1'b1;
      theta = 9'd30;
      @(negedge clk);
      en    = 1'b0;
      theta = 9'd0;
      @(negedge clk);
      en    = 1'b1;
      theta = 9'd60;
      @(negedge clk);
      en    = 1'b0;
      check("ignore busy", int'(busy), 1);
      repeat (3) @(negedge clk);
      check("ignore valid", int'(valid), 1);
      check("ignore cos", s16(cos_q), 7094);
      check("ignore sin", s16(sin_q), 4096);
      $display("ignored-en request -> cos=%0d sin=%0d", s16(cos_q), s16(sin_q));
      vcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (valid || busy) vcount++;
      end
      check("ignore no queued", vcount, 0);
      hold_cos = 7094;
      hold_sin = 4096;

      // Reset while in WAIT_SIN aborts the request.
      @(negedge clk);
      en    = 1'b1;
      theta = 9'd45;
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort busy", int'(busy), 0);
      check("abort valid", int'(valid), 0);
      check("abort cos", s16(cos_q), 0);
      check("abort sin", s16(sin_q), 0);
      $display("abort -> busy=%0d valid=%0d cos=%0d sin=%0d", busy, valid, s16(cos_q), s16(sin_q));
      rst      = 1'b1;
      hold_cos = 0;
      hold_sin = 0;
      vcount   = 0;
      repeat (8) begin
         @(negedge clk);
         if (valid) vcount++;
      end
      check("abort no valid", vcount, 0);
      run_request(60, 4096, 7094);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
